// File: rtl/mips32_mem_pkg.sv
// Shared types and sizing constants for the mips32 shared-memory arbiter.
// Pure declarations: no logic, no latency.
// Backpressure is not applicable here.
package mips32_mem_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   // Deepest supported memory read latency.
   localparam int MEM_LAT_MAX = 4;
   // Latency counter holds 0..MEM_LAT_MAX-1.
   localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX);
   // Fetch starvation counter, saturating.
   localparam int STARVE_W    = 4;
   localparam logic [STARVE_W-1:0] STARVE_SAT = '1;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the shared-memory arbiter.
// No logic, no latency.
// Backpressure: if_ready/d_ready toward the requesters; the memory never stalls.
interface mips32_mem_arbiter_if;
   logic        if_req;
   logic [29:0] if_addr;
   logic        if_ready;
   logic        if_valid;
   logic [31:0] if_rdata;

   logic        d_req;
   logic        d_we;
   logic [29:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_ready;
   logic        d_valid;
   logic [31:0] d_rdata;

   logic        mem_en;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;

   logic        busy;

   // Core and memory side.
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
      input  if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
   );

   // Arbiter side.
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
      output if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
   );
endinterface

// File: rtl/mips32_mem_arb_pick.sv
// Grant selection between fetch and data: data wins ties unless fetch is starved.
// Combinational, zero latency.
// Backpressure: none; the caller only consults the grant in IDLE. Optional fairness: MEM_ARB_FAIR_EN.
module mips32_mem_arb_pick
   import mips32_mem_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic                if_req_i,
   input  logic                d_req_i,
   input  logic [STARVE_W-1:0] starve_cnt_i,
   output logic                grant_d_o
);

`ifdef MEM_ARB_FAIR_EN
   logic if_starved;

   assign if_starved = (starve_cnt_i >= STARVE_W'(STARVE_MAX));
   // A starved fetch takes the tie; otherwise data keeps priority.
   assign grant_d_o  = d_req_i & ~(if_req_i & if_starved);
`else
   logic unused_pick;

   // Strict data priority; the starvation inputs are intentionally ignored.
   assign unused_pick = ^{starve_cnt_i, if_req_i, STARVE_W'(STARVE_MAX)};
   assign grant_d_o   = d_req_i;
`endif

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Shares one single-ported word memory between fetch and load/store, one access at a time.
// Latency: acceptance to valid pulse is MEM_LAT+1 edges; throughput one access per MEM_LAT+1 cycles.
// Backpressure: ready=1 only in IDLE; a requester not granted must hold until accepted. Optional: MEM_ARB_FAIR_EN.
module mips32_mem_arbiter
   import mips32_mem_pkg::*;
#(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   mips32_mem_arbiter_if.slave  bus
);

   arb_state_e           state_q,     state_d;
   owner_e               owner_q,     owner_d;
   logic [LAT_CNT_W-1:0] cnt_q,       cnt_d;
   logic                 we_q,        we_d;
   logic [29:0]          addr_q,      addr_d;
   logic [31:0]          wdata_q,     wdata_d;
   logic [3:0]           be_q,        be_d;
   logic                 if_valid_q,  if_valid_d;
   logic                 d_valid_q,   d_valid_d;
   logic [31:0]          if_rdata_q,  if_rdata_d;
   logic [31:0]          d_rdata_q,   d_rdata_d;
   logic [STARVE_W-1:0]  starve_cnt;
   logic                 grant_d;

`ifdef MEM_ARB_FAIR_EN
   logic [STARVE_W-1:0]  starve_q,    starve_d;

   assign starve_cnt = starve_q;
`else
   assign starve_cnt = '0;
`endif

   mips32_mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .if_req_i     (bus.if_req),
      .d_req_i      (bus.d_req),
      .starve_cnt_i (starve_cnt),
      .grant_d_o    (grant_d)
   );

   // Next-state: grant and latch a request in IDLE, count down and complete in ACCESS.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      if_valid_d = 1'b0;
      d_valid_d  = 1'b0;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_FAIR_EN
      starve_d   = starve_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.if_req || bus.d_req) begin
               state_d = ACCESS;
               cnt_d   = LAT_CNT_W'(MEM_LAT - 1);
               if (grant_d) begin
                  owner_d = OWN_D;
                  we_d    = bus.d_we;
                  addr_d  = bus.d_addr;
                  wdata_d = bus.d_wdata;
                  be_d    = bus.d_be;
               end else begin
                  // Fetch is always a full-word read.
                  owner_d = OWN_IF;
                  we_d    = 1'b0;
                  addr_d  = bus.if_addr;
                  wdata_d = '0;
                  be_d    = 4'hF;
               end
`ifdef MEM_ARB_FAIR_EN
               if (!grant_d) begin
                  starve_d = '0;
               end else if (bus.if_req && starve_q != STARVE_SAT) begin
                  starve_d = starve_q + 1'b1;
               end
`endif
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               if (owner_q == OWN_D) begin
                  d_valid_d = 1'b1;
                  d_rdata_d = we_q ? 32'h0 : bus.mem_rdata;
               end else begin
                  if_valid_d = 1'b1;
                  if_rdata_d = bus.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset drops any in-flight access immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
`ifdef MEM_ARB_FAIR_EN
         starve_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         if_valid_q <= if_valid_d;
         d_valid_q  <= d_valid_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_FAIR_EN
         starve_q   <= starve_d;
`endif
      end
   end

   assign bus.if_ready  = (state_q == IDLE);
   assign bus.d_ready   = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.mem_en    = (state_q == ACCESS);
   assign bus.mem_we    = (state_q == ACCESS) & we_q & (owner_q == OWN_D);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_be    = be_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.d_valid   = d_valid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter against a transaction-level reference model.
// Drives fetch/data requesters, models the word memory, compares every cycle.
// Requesters hold req/addr/data until the model says they were accepted.
module tb_mips32_mem_arbiter;

   localparam int LAT  = 2;
   localparam int SMAX = 2;
`ifdef MEM_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mips32_mem_arbiter_if bus ();

   mips32_mem_arbiter #(
      .MEM_LAT    (LAT),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- memory model ----------------
   logic [31:0] mem [0:255];
   bit          mem_ready;

   function automatic logic [31:0] init_word(input int i);
      logic [31:0] w;
      w = 32'hA5000000 ^ (32'(i) * 32'h00010203);
      if (i == 16) w = 32'h2108000A;
      return w;
   endfunction

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
         mem_ready <= 1'b1;
      end else if (bus.mem_en && bus.mem_we) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_be[b]) mem[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
   end

   assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

   // ---------------- reference model state ----------------
   logic [31:0] ref_mem [0:255];
   bit          m_busy, m_own_d, m_we;
   int          m_left, m_starve;
   logic [29:0] m_addr;
   logic [31:0] e_if_rdata, e_d_rdata;
   bit          e_if_valid, e_d_valid;
   int          cyc, obs_we_cnt;
   bit          obs_log[$];       // 1 = data completion, 0 = fetch completion
   int          if_pulse_cyc[$];
   logic [31:0] obs_d_rdata[$];
   logic [29:0] stream_addr;

   task automatic model_clear();
      m_busy = 0; m_own_d = 0; m_we = 0; m_left = 0; m_starve = 0; m_addr = '0;
      e_if_rdata = '0; e_d_rdata = '0; e_if_valid = 0; e_d_valid = 0;
      cyc = 0; obs_we_cnt = 0; stream_addr = 30'h100;
      obs_log.delete(); if_pulse_cyc.delete(); obs_d_rdata.delete();
   endtask

   task automatic drive_idle();
      bus.if_req = 0; bus.if_addr = '0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive_idle();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
   endtask

   // Advances the model by one edge, lets the DUT take that edge, compares, then picks new stimulus.
   task automatic run_traffic(input int ncyc, input int if_pct, input int d_pct, input bit stream);
      bit acc_if, acc_d, g_d;
      for (int n = 0; n < ncyc; n++) begin
         acc_if = 0; acc_d = 0; e_if_valid = 0; e_d_valid = 0;
         if (!m_busy) begin
            if (bus.if_req || bus.d_req) begin
               g_d = bus.d_req && !(FAIR && bus.if_req && m_starve >= SMAX);
               if (g_d && bus.if_req) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
               if (!g_d) m_starve = 0;
               m_busy = 1; m_left = LAT; m_own_d = g_d;
               if (g_d) begin
                  acc_d = 1; m_addr = bus.d_addr; m_we = bus.d_we;
                  if (bus.d_we)
                     for (int b = 0; b < 4; b++)
                        if (bus.d_be[b]) ref_mem[m_addr[7:0]][8*b +: 8] = bus.d_wdata[8*b +: 8];
               end else begin
                  acc_if = 1; m_addr = bus.if_addr; m_we = 0;
               end
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 0;
               if (m_own_d) begin
                  e_d_valid = 1;
                  e_d_rdata = m_we ? 32'h0 : ref_mem[m_addr[7:0]];
               end else begin
                  e_if_valid = 1;
                  e_if_rdata = ref_mem[m_addr[7:0]];
               end
            end
         end

         @(posedge clk);
         #1;
         cyc++;

         checks += 9;
         if (bus.if_valid !== e_if_valid) begin errors++; $display("FAIL if_valid cyc=%0d got=%b exp=%b", cyc, bus.if_valid, e_if_valid); end
         if (bus.d_valid !== e_d_valid) begin errors++; $display("FAIL d_valid cyc=%0d got=%b exp=%b", cyc, bus.d_valid, e_d_valid); end
         if (bus.if_rdata !== e_if_rdata) begin errors++; $display("FAIL if_rdata cyc=%0d got=%h exp=%h", cyc, bus.if_rdata, e_if_rdata); end
         if (bus.d_rdata !== e_d_rdata) begin errors++; $display("FAIL d_rdata cyc=%0d got=%h exp=%h", cyc, bus.d_rdata, e_d_rdata); end
         if (bus.busy !== m_busy) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, m_busy); end
         if (bus.mem_en !== m_busy) begin errors++; $display("FAIL mem_en cyc=%0d got=%b exp=%b", cyc, bus.mem_en, m_busy); end
         if (bus.mem_we !== (m_busy && m_we)) begin errors++; $display("FAIL mem_we cyc=%0d got=%b exp=%b", cyc, bus.mem_we, m_busy && m_we); end
         if (bus.if_ready !== !m_busy || bus.d_ready !== !m_busy) begin errors++; $display("FAIL ready cyc=%0d got=%b%b exp=%b", cyc, bus.if_ready, bus.d_ready, !m_busy); end
         if (m_busy && bus.mem_addr !== m_addr) begin errors++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, bus.mem_addr, m_addr); end

         if (bus.d_valid) begin obs_log.push_back(1'b1); obs_d_rdata.push_back(bus.d_rdata); end
         if (bus.if_valid) begin obs_log.push_back(1'b0); if_pulse_cyc.push_back(cyc); end
         if (bus.mem_we) obs_we_cnt++;

         if (acc_if) bus.if_req = 0;
         if (acc_d) bus.d_req = 0;
         if (!bus.if_req && $urandom_range(99) < if_pct) begin
            bus.if_req = 1;
            if (stream) begin bus.if_addr = stream_addr; stream_addr = stream_addr + 1; end
            else bus.if_addr = 30'($urandom_range(63));
         end
         if (!bus.d_req && $urandom_range(99) < d_pct) begin
            bus.d_req = 1; bus.d_we = 1'($urandom_range(1));
            bus.d_addr = 30'($urandom_range(63)); bus.d_wdata = $urandom;
            bus.d_be = 4'($urandom_range(15));
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      checks += 6;
      if (bus.if_ready !== 1'b1 || bus.d_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b%b exp=11", bus.if_ready, bus.d_ready); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_en_we got=%b%b exp=00", bus.mem_en, bus.mem_we); end
      if (bus.mem_addr !== 30'h0 || bus.mem_wdata !== 32'h0 || bus.mem_be !== 4'h0) begin errors++; $display("FAIL reset_mem_bus got=%h/%h/%h exp=0", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
      if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b%b exp=00", bus.if_valid, bus.d_valid); end
      if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0", bus.if_rdata, bus.d_rdata); end
      do_reset();
   endtask

   task automatic test_fetch();
      do_reset();
      bus.if_req = 1; bus.if_addr = 30'h10;
      run_traffic(LAT + 3, 0, 0, 0);
      checks += 3;
      if (if_pulse_cyc.size() !== 1 || if_pulse_cyc[0] !== LAT + 1) begin errors++; $display("FAIL fetch_latency pulses=%0d first_at=%0d exp_at=%0d", if_pulse_cyc.size(), (if_pulse_cyc.size() > 0) ? if_pulse_cyc[0] : -1, LAT + 1); end
      if (bus.if_rdata !== 32'h2108000A) begin errors++; $display("FAIL fetch_rdata got=%h exp=2108000a", bus.if_rdata); end
      if (obs_d_rdata.size() !== 0) begin errors++; $display("FAIL fetch_no_dvalid got=%0d exp=0", obs_d_rdata.size()); end
   endtask

   task automatic test_store_load();
      do_reset();
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 30'h20; bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'b1111;
      run_traffic(LAT + 2, 0, 0, 0);
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 30'h20;
      run_traffic(LAT + 2, 0, 0, 0);
      checks += 3;
      if (obs_we_cnt !== LAT) begin errors++; $display("FAIL store_we_cycles got=%0d exp=%0d", obs_we_cnt, LAT); end
      if (obs_d_rdata.size() !== 2) begin errors++; $display("FAIL store_load_count got=%0d exp=2", obs_d_rdata.size()); end
      else begin
         checks += 1;
         if (obs_d_rdata[0] !== 32'h0) begin errors++; $display("FAIL store_rdata got=%h exp=0", obs_d_rdata[0]); end
      end
      if (bus.d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got=%h exp=deadbeef", bus.d_rdata); end
   endtask

   task automatic test_contention();
      bit exp_d;
      do_reset();
      run_traffic(6 * (LAT + 1) + 1, 100, 100, 0);
      checks += 1;
      if (obs_log.size() < 6) begin errors++; $display("FAIL contention_count got=%0d exp>=6", obs_log.size()); end
      for (int i = 0; i < 6 && i < obs_log.size(); i++) begin
         exp_d = !(FAIR && (i % (SMAX + 1)) == SMAX);
         checks++;
         if (obs_log[i] !== exp_d) begin errors++; $display("FAIL contention_order idx=%0d got_d=%b exp_d=%b", i, obs_log[i], exp_d); end
      end
   endtask

   task automatic test_reset_mid_access();
      do_reset();
      bus.if_req = 1; bus.if_addr = 30'h5;
      @(posedge clk); #1;             // acceptance edge: first ACCESS cycle
      bus.if_req = 0;
      @(posedge clk); #1;             // second ACCESS cycle
      reset = 1'b1;
      #1;
      checks += 2;
      if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL midreset_mem_en got=%b exp=0", bus.mem_en); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", bus.busy); end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
      for (int k = 0; k < LAT + 2; k++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_valid k=%0d got=%b%b exp=00", k, bus.if_valid, bus.d_valid); end
      end
      bus.if_req = 1; bus.if_addr = 30'h10;
      run_traffic(LAT + 3, 0, 0, 0);
      checks += 2;
      if (if_pulse_cyc.size() !== 1) begin errors++; $display("FAIL midreset_refetch pulses=%0d exp=1", if_pulse_cyc.size()); end
      if (bus.if_rdata !== 32'h2108000A) begin errors++; $display("FAIL midreset_rdata got=%h exp=2108000a", bus.if_rdata); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_traffic(8 * (LAT + 1) + 2, 100, 0, 1);
      checks += 1;
      if (if_pulse_cyc.size() < 6) begin errors++; $display("FAIL stream_pulses got=%0d exp>=6", if_pulse_cyc.size()); end
      for (int i = 1; i < if_pulse_cyc.size(); i++) begin
         checks++;
         if (if_pulse_cyc[i] - if_pulse_cyc[i-1] !== LAT + 1) begin errors++; $display("FAIL stream_interval idx=%0d got=%0d exp=%0d", i, if_pulse_cyc[i] - if_pulse_cyc[i-1], LAT + 1); end
      end
   endtask

   task automatic test_random();
      do_reset();
      run_traffic(600, 40, 40, 0);
      checks += 1;
      if (obs_log.size() < 50) begin errors++; $display("FAIL random_throughput got=%0d exp>=50", obs_log.size()); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      model_clear();
      test_reset();
      test_fetch();
      test_store_load();
      test_contention();
      test_reset_mid_access();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips32_mem_arbiter.md
# mips32_mem_arbiter

Two-requester arbiter that shares one single-ported word memory between instruction fetch and load/store in the mips32 core. It replaces the separate ideal instruction and data memories with one `ideal_instr_mem`-style array. The fetch and data ports each see a req/ready/valid handshake. The arbiter sequences one access at a time through a fixed-latency memory pipeline, and `busy` gives the core's stall logic the state of the shared port.

## Interface
Parameters:
- MEM_LAT, 1: memory read latency in cycles; legal range 1..4.
- STARVE_MAX, 4: fetch losses tolerated before fetch is forced to win. Used only under MEM_ARB_FAIR_EN; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request.
- if_addr  in  30  fetch word address (PC[31:2]).
- if_ready  out  1  fetch request is accepted at this edge when if_req is also high.
- if_valid  out  1  one-cycle pulse; if_rdata holds the fetched word.
- if_rdata  out  32  fetched instruction.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  30  data word address.
- d_wdata  in  32  store data.
- d_be  in  4  store byte enables.
- d_ready  out  1  data request is accepted at this edge when d_req is also high.
- d_valid  out  1  one-cycle completion pulse, for loads and stores.
- d_rdata  out  32  load data; 0 for stores.
- mem_en  out  1  memory access in progress.
- mem_we  out  1  memory write strobe.
- mem_addr  out  30  memory word address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  32  memory read data.
- busy  out  1  the arbiter is not in IDLE.

## Operation
- FSM states:
  - IDLE: if_ready = d_ready = 1 (combinational from state).
  - ACCESS: both ready = 0.
- IDLE with no request: stay in IDLE.
- IDLE with a winning request:
  - latch address, we, wdata and be into the mem_* output registers;
  - record the owner (IF or D);
  - load the latency counter with MEM_LAT-1;
  - go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_we = latched we & owner==D, held for the whole ACCESS;
  - the counter decrements each edge;
  - at the edge where the counter is 0: capture mem_rdata into the owner's rdata register (0 if store), pulse the owner's valid, return to IDLE.
- Only the owner's ready is accepted. The non-winning requester sees ready = 1 but is not accepted; this is the requester's hold condition. Requesters hold req/addr/data until accepted.
- Arbitration without MEM_ARB_FAIR_EN: strict data priority. A tie goes to D.
- Fetch requests are never issued with we; if_* carries no write path.
- rdata registers hold their value until the next completion for that port.

## Timing
- Acceptance edge t0. mem_en is high in cycles t0..t0+MEM_LAT. The completion edge is t0+MEM_LAT. valid is high in the cycle after the completion edge.
- Latency from acceptance to valid: MEM_LAT+1 edges. Throughput: one access per MEM_LAT+1 cycles.
- Back-to-back: in the valid cycle the FSM is in IDLE, so a new request is accepted at the edge where valid falls.
- Memory contract: mem_rdata is valid at the completion edge. Writes commit on the first ACCESS edge.
- Reset values: state IDLE, if_valid/d_valid 0, if_rdata/d_rdata 0, mem_en/mem_we 0, mem_addr/mem_wdata 0, mem_be 0, busy 0, starvation counter 0. if_ready/d_ready read 1 during reset.
- Reset mid-ACCESS: the in-flight access is dropped, no valid pulse is produced, and mem_en drops asynchronously.
- A req deasserted while not yet accepted is not a protocol violation; the request is simply ignored.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - a 4-bit counter increments each IDLE edge where if_req loses to d_req;
  - when counter ≥ STARVE_MAX, the next tie goes to IF;
  - the counter clears on any IF grant.
- MEM_ARB_FAIR_EN undefined: no counter is present and strict data priority applies.

## Structure
- Package mips32_mem_pkg holds:
  - the state enum (IDLE, ACCESS);
  - the owner encoding (OWN_IF=0, OWN_D=1);
  - MEM_LAT_MAX=4 and the counter width constants.
- Sub-module mips32_mem_arb_pick:
  - inputs: if_req, d_req, starvation counter;
  - output: grant_d;
  - holds the tie policy and the MEM_ARB_FAIR_EN logic.
- mips32_mem_arbiter holds the FSM, the latency counter and the output registers.

## Test plan
- MEM_LAT=1, single fetch at addr 0x10 with memory word 0x2108000A: if_valid is high exactly 2 edges after acceptance, if_rdata=0x2108000A, d_valid stays 0.
- d_req store at addr 0x20, wdata 0xDEADBEEF, be=4'b1111, then load at 0x20: mem_we high one ACCESS phase, the store completion has d_rdata=0, the load returns 0xDEADBEEF.
- if_req and d_req held simultaneously without MEM_ARB_FAIR_EN: D is served every time and if_valid never pulses while d_req stays high.
- Same stimulus with MEM_ARB_FAIR_EN, STARVE_MAX=2: the grant order is D,D,IF,D,D,IF.
- MEM_LAT=3, reset asserted on the second ACCESS cycle: mem_en=0 immediately, no valid pulse, busy=0, and the next fetch completes normally.
- MEM_LAT=2, continuous if_req at incrementing addresses: if_valid pulses every 3 cycles and addresses appear on mem_addr in order.
